// File: rtl/vn_packer.sv
// Von Neumann debiaser with MSB-first word packing and a single-entry output slot.
// Equal pairs and words lost to backpressure are counted for entropy health monitoring.
//
// state     | meaning
// PH_FIRST  | waiting for the first bit of a pair (always here in bypass mode)
// PH_SECOND | first bit stored in first_q, next enabled sample closes the pair
module vn_packer #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              bit_in,
   input  logic              mode,
   input  logic              word_ready,
   input  logic              clr_stats,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   output logic              overflow,
   output logic [CNT_W-1:0]  discard_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int BC_W = $clog2(WORD_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      PH_FIRST  = 1'b0,
      PH_SECOND = 1'b1
   } phase_t;

   phase_t            phase_q, phase_d;
   logic              mode_q;
   logic              first_q, first_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [BC_W-1:0]   bcnt_q, bcnt_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  disc_q, disc_d;
   logic [CNT_W-1:0]  drop_q, drop_d;

   logic              mode_chg;
   logic              sample;
   logic              ext_vld;
   logic              ext_bit;
   logic              equal_pair;
   logic              word_done;
   logic              word_drop;
   logic [WORD_W-1:0] completed;

   assign mode_chg = (mode != mode_q);
   assign sample   = enable && !mode_chg;

   // Bit extraction: bypass passes every sample, otherwise only unequal pairs yield a bit.
   always_comb begin
      ext_vld    = 1'b0;
      ext_bit    = 1'b0;
      equal_pair = 1'b0;
      phase_d    = phase_q;
      first_d    = first_q;
      if (mode_chg) begin
         phase_d = PH_FIRST;
      end else if (sample) begin
         if (mode) begin
            ext_vld = 1'b1;
            ext_bit = bit_in;
            phase_d = PH_FIRST;
         end else if (phase_q == PH_FIRST) begin
            first_d = bit_in;
            phase_d = PH_SECOND;
         end else begin
            phase_d = PH_FIRST;
            if (first_q != bit_in) begin
               ext_vld = 1'b1;
               ext_bit = first_q;
            end else begin
               equal_pair = 1'b1;
            end
         end
      end
   end

   assign completed = {acc_q[WORD_W-2:0], ext_bit};

   always_comb begin
      acc_d     = acc_q;
      bcnt_d    = bcnt_q;
      word_done = 1'b0;
      if (mode_chg) begin
         acc_d  = '0;
         bcnt_d = '0;
      end else if (ext_vld) begin
         acc_d = completed;
         if (bcnt_q == LAST_BIT) begin
            bcnt_d    = '0;
            word_done = 1'b1;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end
   end

   // Output slot: a finished word may replace one being accepted on the same edge.
   always_comb begin
      word_d    = word_q;
      valid_d   = valid_q;
      word_drop = 1'b0;
      if (word_done) begin
         if (!valid_q || word_ready) begin
            word_d  = completed;
            valid_d = 1'b1;
         end else begin
            word_drop = 1'b1;
         end
      end else if (valid_q && word_ready) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      disc_d = disc_q;
      drop_d = drop_q;
      ovf_d  = ovf_q;
      if (clr_stats) begin
         disc_d = '0;
         drop_d = '0;
         ovf_d  = 1'b0;
      end else begin
         if (equal_pair && (disc_q != CNT_MAX)) begin
            disc_d = disc_q + 1'b1;
         end
         if (word_drop) begin
            ovf_d = 1'b1;
            if (drop_q != CNT_MAX) begin
               drop_d = drop_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= PH_FIRST;
         mode_q  <= 1'b0;
         first_q <= 1'b0;
         acc_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         disc_q  <= '0;
         drop_q  <= '0;
      end else begin
         phase_q <= phase_d;
         mode_q  <= mode;
         first_q <= first_d;
         acc_q   <= acc_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         disc_q  <= disc_d;
         drop_q  <= drop_d;
      end
   end

   assign word_out    = word_q;
   assign word_valid  = valid_q;
   assign overflow    = ovf_q;
   assign discard_cnt = disc_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_vn_packer.sv
// Directed bench for vn_packer: expected words queued at stimulus time and
// compared on each accepted handshake; a CNT_W=4 copy exercises saturation.
module tb_vn_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       bit_in;
   logic       mode;
   logic       word_ready;
   logic       clr_stats;

   logic [7:0]  word_out;
   logic        word_valid;
   logic        overflow;
   logic [15:0] discard_cnt;
   logic [15:0] drop_cnt;

   logic [7:0]  w2_out;
   logic        w2_valid;
   logic        w2_ovf;
   logic [3:0]  w2_disc;
   logic [3:0]  w2_drop;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   vn_packer #(.WORD_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .mode(mode),
      .word_ready(word_ready), .clr_stats(clr_stats),
      .word_out(word_out), .word_valid(word_valid), .overflow(overflow),
      .discard_cnt(discard_cnt), .drop_cnt(drop_cnt)
   );

   vn_packer #(.WORD_W(8), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .mode(mode),
      .word_ready(word_ready), .clr_stats(clr_stats),
      .word_out(w2_out), .word_valid(w2_valid), .overflow(w2_ovf),
      .discard_cnt(w2_disc), .drop_cnt(w2_drop)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs seen at the next rising edge are sampled here, half a cycle early.
   always @(negedge clk) begin
      if (!rst && word_valid && word_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected: observed word %0h expected no word", word_out);
         end else begin
            chk("sb_word", {24'h0, word_out}, {24'h0, sb.pop_front()});
         end
      end
   end

   task automatic drive(input logic en, input logic b);
      enable = en;
      bit_in = b;
      @(posedge clk);
      #1;
   endtask

   task automatic pair(input logic a, input logic b);
      drive(1'b1, a);
      drive(1'b1, b);
   endtask

   task automatic vn_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) pair(w[i], ~w[i]);
   endtask

   initial begin
      logic [7:0] w;
      rst        = 1'b1;
      enable     = 1'b0;
      bit_in     = 1'b0;
      mode       = 1'b0;
      word_ready = 1'b0;
      clr_stats  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_word_out", {24'h0, word_out}, 32'h0);
      chk("rst_valid", {31'h0, word_valid}, 32'h0);
      chk("rst_overflow", {31'h0, overflow}, 32'h0);
      chk("rst_discard", {16'h0, discard_cnt}, 32'h0);
      chk("rst_drop", {16'h0, drop_cnt}, 32'h0);
      rst = 1'b0;
      word_ready = 1'b1;
      drive(1'b0, 1'b0);

      // Basic extraction: pairs 10,01,10,10,01,01,10,01
      sb.push_back(8'hB2);
      vn_word(8'hB2);
      chk("t1_valid_hi", {31'h0, word_valid}, 32'h1);
      chk("t1_word", {24'h0, word_out}, 32'hB2);
      drive(1'b0, 1'b0);
      chk("t1_valid_one_cycle", {31'h0, word_valid}, 32'h0);
      chk("t1_discard", {16'h0, discard_cnt}, 32'h0);

      // Equal pairs interleaved, one pair split by 5 disabled cycles
      w = 8'h3A;
      sb.push_back(w);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) pair((i % 4) != 0, (i % 4) != 0);
         if (i == 3) begin
            drive(1'b1, w[7-i]);
            repeat (5) drive(1'b0, 1'($urandom_range(1, 0)));
            drive(1'b1, ~w[7-i]);
         end else begin
            pair(w[7-i], ~w[7-i]);
         end
      end
      chk("t2_word", {24'h0, word_out}, 32'h3A);
      chk("t2_discard", {16'h0, discard_cnt}, 32'd4);
      drive(1'b0, 1'b0);

      // Backpressure: second word is dropped
      word_ready = 1'b0;
      sb.push_back(8'hB2);
      vn_word(8'hB2);
      vn_word(8'h4D);
      chk("t3_word_held", {24'h0, word_out}, 32'hB2);
      chk("t3_valid", {31'h0, word_valid}, 32'h1);
      chk("t3_overflow", {31'h0, overflow}, 32'h1);
      chk("t3_drop", {16'h0, drop_cnt}, 32'h1);
      word_ready = 1'b1;
      drive(1'b0, 1'b0);
      chk("t3_drained", {31'h0, word_valid}, 32'h0);

      // Bypass mode, then a mode toggle mid-word
      mode = 1'b1;
      drive(1'b0, 1'b0);
      sb.push_back(8'hA5);
      w = 8'hA5;
      for (int i = 7; i >= 0; i--) drive(1'b1, w[i]);
      chk("t4_word", {24'h0, word_out}, 32'hA5);
      chk("t4_valid", {31'h0, word_valid}, 32'h1);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      mode = 1'b0;
      drive(1'b1, 1'b1);
      sb.push_back(8'h5C);
      vn_word(8'h5C);
      chk("t4_fresh_word", {24'h0, word_out}, 32'h5C);
      chk("t4_drop_kept", {16'h0, drop_cnt}, 32'h1);
      drive(1'b0, 1'b0);

      // Async reset mid-word with a pending first bit
      pair(1'b1, 1'b0);
      pair(1'b0, 1'b1);
      pair(1'b1, 1'b0);
      pair(1'b1, 1'b0);
      pair(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t5_word_out", {24'h0, word_out}, 32'h0);
      chk("t5_valid", {31'h0, word_valid}, 32'h0);
      chk("t5_overflow", {31'h0, overflow}, 32'h0);
      chk("t5_discard", {16'h0, discard_cnt}, 32'h0);
      chk("t5_drop", {16'h0, drop_cnt}, 32'h0);
      #1 rst = 1'b0;
      sb.push_back(8'hC3);
      vn_word(8'hC3);
      chk("t5_word_after", {24'h0, word_out}, 32'hC3);
      drive(1'b0, 1'b0);

      // Saturation on the 4-bit copy and clear-wins-over-increment
      word_ready = 1'b0;
      sb.push_back(8'h96);
      vn_word(8'h96);
      vn_word(8'h69);
      chk("t6_small_ovf", {31'h0, w2_ovf}, 32'h1);
      for (int i = 0; i < 20; i++) pair(1'(i % 2), 1'(i % 2));
      chk("t6_disc_wide", {16'h0, discard_cnt}, 32'd20);
      chk("t6_disc_sat", {28'h0, w2_disc}, 32'd15);
      drive(1'b1, 1'b1);
      clr_stats = 1'b1;
      drive(1'b1, 1'b1);
      clr_stats = 1'b0;
      chk("t6_clr_disc", {16'h0, discard_cnt}, 32'h0);
      chk("t6_clr_disc_small", {28'h0, w2_disc}, 32'h0);
      chk("t6_clr_ovf", {31'h0, overflow}, 32'h0);
      chk("t6_clr_drop", {16'h0, drop_cnt}, 32'h0);
      chk("t6_clr_drop_small", {28'h0, w2_drop}, 32'h0);
      chk("t6_small_word", {24'h0, w2_out}, 32'h96);
      chk("t6_valid_kept", {31'h0, w2_valid}, 32'h1);
      word_ready = 1'b1;
      drive(1'b0, 1'b0);
      chk("t6_drained", {31'h0, word_valid}, 32'h0);

      drive(1'b0, 1'b0);
      chk("sb_empty", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
